// File: rtl/snn_sched_pkg.sv
// Shared types and helpers for the spike event scheduler.
package snn_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RUN  = 3'd1,
      ST_RD   = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } sched_state_e;

   // Encoded so the reset value (all zero) selects the update path.
   typedef enum logic {
      SW_UPD = 1'b0,
      SW_ACC = 1'b1
   } sweep_e;

   // Synapse rows below this value belong to external sources; the top
   // NR_DEPTH rows are the recurrent rows of the internal neurons.
   function automatic int unsigned ext_rows(input int unsigned sr_depth,
                                            input int unsigned nr_depth);
      return sr_depth - nr_depth;
   endfunction

endpackage

// File: rtl/spike_mask_encoder.sv
// Lowest-set-bit priority encoder over the pending fire mask.
module spike_mask_encoder #(
   parameter int unsigned WIDTH = 16,
   localparam int unsigned IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] mask,
   output logic             any,
   output logic [IW-1:0]    idx
);

   // Scan downwards so the lowest set bit is the last one written.
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            any = 1'b1;
            idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/spike_event_scheduler.sv
// Event sequencer for the time-multiplexed neuron datapath: queues external and
// recurrent spikes and runs accumulate/update sweeps. Option: SCHED_RECURRENT_EN.
module spike_event_scheduler
   import snn_sched_pkg::*;
#(
   parameter int unsigned NR_DEPTH         = 16,
   parameter int unsigned SR_DEPTH         = 16384,
   parameter int unsigned FIFO_DEPTH       = 8,
   parameter int unsigned MAX_NETWORK_TIME = 65536
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic                                ext_valid,
   input  logic [$clog2(SR_DEPTH)-1:0]         ext_index,
   output logic                                ext_ready,
   input  logic                                tick,
   input  logic                                fire,
   output logic [$clog2(NR_DEPTH)-1:0]         c_neuron_index,
   output logic [$clog2(SR_DEPTH)-1:0]         c_synapse_index,
   output logic                                c_neuron_we,
   output logic                                c_input,
   output logic                                spike_out_valid,
   output logic [$clog2(NR_DEPTH)-1:0]         spike_out_index,
   output logic [$clog2(MAX_NETWORK_TIME)-1:0] network_time,
   output logic                                busy,
   output logic                                done
);

   localparam int unsigned NIW      = $clog2(NR_DEPTH);
   localparam int unsigned SIW      = $clog2(SR_DEPTH);
   localparam int unsigned FAW      = $clog2(FIFO_DEPTH);
   localparam int unsigned PW       = FAW + 1;
   localparam int unsigned TW       = $clog2(MAX_NETWORK_TIME);
   localparam int unsigned EXT_ROWS = ext_rows(SR_DEPTH, NR_DEPTH);

   sched_state_e   state_q, state_d;
   sweep_e         sweep_q, sweep_d;
   logic [NIW-1:0] cnt_q, cnt_d;
   logic [SIW-1:0] row_q, row_d;
   logic           tick_pend_q, tick_pend_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic           spk_valid_q, spk_valid_d;
   logic [NIW-1:0] spk_idx_q, spk_idx_d;
   logic [TW-1:0]  ntime_q, ntime_d;
   logic [SIW-1:0] fifo_mem_q [FIFO_DEPTH];

   logic fifo_empty;
   logic fifo_full;
   logic fifo_push;
   logic active;

`ifdef SCHED_RECURRENT_EN
   logic [NR_DEPTH-1:0] mask_q, mask_d;
   logic                mask_any;
   logic [NIW-1:0]      mask_idx;

   spike_mask_encoder #(
      .WIDTH (NR_DEPTH)
   ) u_mask_enc (
      .mask (mask_q),
      .any  (mask_any),
      .idx  (mask_idx)
   );
`endif

   // FIFO status; the extra pointer bit separates full from empty.
   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[FAW] != rd_ptr_q[FAW]) &&
                   (wr_ptr_q[FAW-1:0] == rd_ptr_q[FAW-1:0]);
      active     = (state_q == ST_RUN) || (state_q == ST_RD) || (state_q == ST_WR);
      fifo_push  = ext_valid && !fifo_full && active;
      wr_ptr_d   = fifo_push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
   end

   // Next-state: arbitration in RUN, sweep sequencing in RD/WR.
   always_comb begin
      state_d     = state_q;
      sweep_d     = sweep_q;
      cnt_d       = cnt_q;
      row_d       = row_q;
      tick_pend_d = tick_pend_q | tick;
      rd_ptr_d    = rd_ptr_q;
      spk_valid_d = 1'b0;
      spk_idx_d   = spk_idx_q;
      ntime_d     = ntime_q;
`ifdef SCHED_RECURRENT_EN
      mask_d      = mask_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_RUN;
         end

         ST_RUN: begin
`ifdef SCHED_RECURRENT_EN
            if (mask_any) begin
               state_d          = ST_RD;
               sweep_d          = SW_ACC;
               cnt_d            = '0;
               row_d            = SIW'(EXT_ROWS) + SIW'(mask_idx);
               mask_d[mask_idx] = 1'b0;
            end else
`endif
            if (tick_pend_q) begin
               state_d     = ST_RD;
               sweep_d     = SW_UPD;
               cnt_d       = '0;
               row_d       = '0;
               tick_pend_d = tick;
            end else if (!fifo_empty) begin
               state_d  = ST_RD;
               sweep_d  = SW_ACC;
               cnt_d    = '0;
               row_d    = fifo_mem_q[rd_ptr_q[FAW-1:0]];
               rd_ptr_d = rd_ptr_q + PW'(1);
            end
         end

         ST_RD: begin
            state_d = ST_WR;
         end

         ST_WR: begin
            if ((sweep_q == SW_UPD) && fire) begin
               spk_valid_d = 1'b1;
               spk_idx_d   = cnt_q;
`ifdef SCHED_RECURRENT_EN
               mask_d[cnt_q] = 1'b1;
`endif
            end
            if (cnt_q == NIW'(NR_DEPTH - 1)) begin
               cnt_d   = '0;
               state_d = ST_RUN;
               if (sweep_q == SW_UPD) begin
                  if (ntime_q == TW'(MAX_NETWORK_TIME - 1)) state_d = ST_DONE;
                  else                                      ntime_d = ntime_q + TW'(1);
               end
            end else begin
               cnt_d   = cnt_q + NIW'(1);
               state_d = ST_RD;
            end
         end

         ST_DONE: begin
            state_d = ST_DONE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         sweep_q     <= SW_UPD;
         cnt_q       <= '0;
         row_q       <= '0;
         tick_pend_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         spk_valid_q <= 1'b0;
         spk_idx_q   <= '0;
         ntime_q     <= '0;
      end else begin
         state_q     <= state_d;
         sweep_q     <= sweep_d;
         cnt_q       <= cnt_d;
         row_q       <= row_d;
         tick_pend_q <= tick_pend_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         spk_valid_q <= spk_valid_d;
         spk_idx_q   <= spk_idx_d;
         ntime_q     <= ntime_d;
      end
   end

`ifdef SCHED_RECURRENT_EN
   always_ff @(posedge clk) begin
      if (reset) mask_q <= '0;
      else       mask_q <= mask_d;
   end
`endif

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (!reset && fifo_push) fifo_mem_q[wr_ptr_q[FAW-1:0]] <= ext_index;
   end

   always_comb begin
      ext_ready       = !fifo_full && active;
      c_neuron_index  = cnt_q;
      c_synapse_index = row_q;
      c_neuron_we     = (state_q == ST_WR);
      c_input         = (sweep_q == SW_ACC);
      spike_out_valid = spk_valid_q;
      spike_out_index = spk_idx_q;
      network_time    = ntime_q;
      busy            = (state_q == ST_RD) || (state_q == ST_WR);
      done            = (state_q == ST_DONE);
   end

endmodule

// File: tb/tb_spike_event_scheduler.sv
// Directed self-checking bench for spike_event_scheduler (MAX_NETWORK_TIME = 4).
module tb_spike_event_scheduler;

   localparam int unsigned EXT_ROWS = 16384 - 16;

   logic        clk;
   logic        reset;
   logic        start;
   logic        ext_valid;
   logic [13:0] ext_index;
   logic        ext_ready;
   logic        tick;
   logic        fire;
   logic [3:0]  c_neuron_index;
   logic [13:0] c_synapse_index;
   logic        c_neuron_we;
   logic        c_input;
   logic        spike_out_valid;
   logic [3:0]  spike_out_index;
   logic [1:0]  network_time;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [15:0] fire_mask = 16'h0000;
   logic        busy_prev = 1'b0;
   int          log_row[$];
   logic        log_acc[$];
   int          log_cyc[$];
   int          spike_log[$];

   spike_event_scheduler #(
      .NR_DEPTH         (16),
      .SR_DEPTH         (16384),
      .FIFO_DEPTH       (8),
      .MAX_NETWORK_TIME (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .ext_valid       (ext_valid),
      .ext_index       (ext_index),
      .ext_ready       (ext_ready),
      .tick            (tick),
      .fire            (fire),
      .c_neuron_index  (c_neuron_index),
      .c_synapse_index (c_synapse_index),
      .c_neuron_we     (c_neuron_we),
      .c_input         (c_input),
      .spike_out_valid (spike_out_valid),
      .spike_out_index (spike_out_index),
      .network_time    (network_time),
      .busy            (busy),
      .done            (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // Neuron processor stand-in plus a log of sweep starts and spikes.
   always @(negedge clk) begin
      fire = c_neuron_we && fire_mask[c_neuron_index];
      if (busy && !busy_prev) begin
         log_row.push_back(int'(c_synapse_index));
         log_acc.push_back(c_input);
         log_cyc.push_back(cyc);
      end
      if (spike_out_valid) spike_log.push_back(int'(spike_out_index));
      busy_prev = busy;
   end

   task automatic clear_logs();
      log_row.delete();
      log_acc.delete();
      log_cyc.delete();
      spike_log.delete();
   endtask

   task automatic wait_sweeps(input int n, output logic timeout);
      int k = 0;
      while (!(log_row.size() >= n && !busy) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      timeout = (k >= 3000);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, done, ext_ready, c_neuron_we, c_input, spike_out_valid} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_flags got=%b exp=000000",
                  {busy, done, ext_ready, c_neuron_we, c_input, spike_out_valid});
      end
      n_cmp++;
      if (c_neuron_index !== 4'd0 || c_synapse_index !== 14'd0 ||
          spike_out_index !== 4'd0 || network_time !== 2'd0) begin
         n_bad++;
         $display("FAIL reset_values nidx=%0d sidx=%0d spk=%0d nt=%0d exp all 0",
                  c_neuron_index, c_synapse_index, spike_out_index, network_time);
      end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ext_ready !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_after_reset ready=%b busy=%b exp 0 0", ext_ready, busy);
      end
   endtask

   task automatic test_single_event();
      int nwe = 0;
      pulse_start();
      n_cmp++;
      if (ext_ready !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL start_run ready=%b busy=%b exp 1 0", ext_ready, busy);
      end
      ext_valid = 1'b1;
      ext_index = 14'd5;
      @(negedge clk);
      ext_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL run_cycle busy=%b exp 0", busy);
      end
      @(negedge clk);
      for (int k = 0; k < 32; k++) begin
         n_cmp++;
         if (c_neuron_index !== 4'(k / 2) || c_neuron_we !== 1'(k % 2) ||
             c_synapse_index !== 14'd5 || c_input !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL sweep_cycle%0d idx=%0d we=%b row=%0d in=%b busy=%b exp idx=%0d we=%0d row=5 in=1 busy=1",
                     k, c_neuron_index, c_neuron_we, c_synapse_index, c_input, busy, k / 2, k % 2);
         end
         if (c_neuron_we === 1'b1) nwe++;
         @(negedge clk);
      end
      n_cmp++;
      if (busy !== 1'b0 || c_neuron_we !== 1'b0) begin
         n_bad++;
         $display("FAIL back_in_run busy=%b we=%b exp 0 0", busy, c_neuron_we);
      end
      n_cmp++;
      if (nwe != 16) begin
         n_bad++;
         $display("FAIL we_pulses got=%0d exp=16", nwe);
      end
   endtask

   task automatic test_fifo_full_order();
      int   acc = 0;
      int   k   = 0;
      logic to;
      clear_logs();
      ext_valid = 1'b1;
      ext_index = 14'd100;
      @(negedge clk);
      ext_valid = 1'b0;
      while (!busy && k < 20) begin
         @(negedge clk);
         k++;
      end
      ext_valid = 1'b1;
      ext_index = 14'd200;
      for (int i = 0; i < 12; i++) begin
         if (ext_ready) acc++;
         @(negedge clk);
         ext_index = 14'(200 + acc);
      end
      n_cmp++;
      if (acc != 8 || ext_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL fifo_full accepted=%0d ready=%b exp 8 0", acc, ext_ready);
      end
      k = 0;
      while (!ext_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      ext_valid = 1'b0;
      wait_sweeps(10, to);
      n_cmp++;
      if (to !== 1'b0 || log_row.size() != 10) begin
         n_bad++;
         $display("FAIL fifo_sweeps timeout=%b count=%0d exp 0 10", to, log_row.size());
      end
      for (int i = 0; i < 10 && i < log_row.size(); i++) begin
         n_cmp++;
         if (log_row[i] != ((i == 0) ? 100 : 199 + i) || log_acc[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL fifo_order%0d row=%0d acc=%b exp row=%0d acc=1",
                     i, log_row[i], log_acc[i], (i == 0) ? 100 : 199 + i);
         end
      end
   endtask

   task automatic test_fire_feedback();
      logic to;
      int   exp_row[$];
      logic exp_acc[$];
`ifdef SCHED_RECURRENT_EN
      exp_row = '{0, EXT_ROWS + 3, EXT_ROWS + 7, 50};
      exp_acc = '{1'b0, 1'b1, 1'b1, 1'b1};
`else
      exp_row = '{0, 50};
      exp_acc = '{1'b0, 1'b1};
`endif
      clear_logs();
      fire_mask = 16'h0088;
      ext_valid = 1'b1;
      ext_index = 14'd50;
      tick      = 1'b1;
      @(negedge clk);
      ext_valid = 1'b0;
      tick      = 1'b0;
      wait_sweeps(exp_row.size(), to);
      fire_mask = 16'h0000;
      repeat (40) @(negedge clk);
      n_cmp++;
      if (to !== 1'b0 || log_row.size() != exp_row.size()) begin
         n_bad++;
         $display("FAIL fire_sweeps timeout=%b count=%0d exp 0 %0d", to, log_row.size(), exp_row.size());
      end
      for (int i = 0; i < exp_row.size() && i < log_row.size(); i++) begin
         n_cmp++;
         if (log_acc[i] !== exp_acc[i] || (exp_acc[i] && log_row[i] != exp_row[i])) begin
            n_bad++;
            $display("FAIL fire_seq%0d row=%0d acc=%b exp row=%0d acc=%b",
                     i, log_row[i], log_acc[i], exp_row[i], exp_acc[i]);
         end
         if (i > 0) begin
            n_cmp++;
            if (log_cyc[i] - log_cyc[i-1] != 33) begin
               n_bad++;
               $display("FAIL back_to_back%0d gap=%0d exp=33", i, log_cyc[i] - log_cyc[i-1]);
            end
         end
      end
      n_cmp++;
      if (spike_log.size() != 2 || (spike_log.size() == 2 && (spike_log[0] != 3 || spike_log[1] != 7))) begin
         n_bad++;
         $display("FAIL spike_out count=%0d first=%0d exp 2 spikes 3 then 7",
                  spike_log.size(), (spike_log.size() > 0) ? spike_log[0] : -1);
      end
      n_cmp++;
      if (network_time !== 2'd1) begin
         n_bad++;
         $display("FAIL time_after_tick got=%0d exp=1", network_time);
      end
   endtask

   task automatic test_tick_priority();
      logic to;
      clear_logs();
      ext_valid = 1'b1;
      ext_index = 14'd60;
      tick      = 1'b1;
      @(negedge clk);
      tick      = 1'b0;
      ext_index = 14'd61;
      @(negedge clk);
      ext_valid = 1'b0;
      wait_sweeps(3, to);
      n_cmp++;
      if (to !== 1'b0 || log_row.size() != 3) begin
         n_bad++;
         $display("FAIL prio_sweeps timeout=%b count=%0d exp 0 3", to, log_row.size());
      end else begin
         n_cmp++;
         if (log_acc[0] !== 1'b0 || log_acc[1] !== 1'b1 || log_row[1] != 60 ||
             log_acc[2] !== 1'b1 || log_row[2] != 61) begin
            n_bad++;
            $display("FAIL prio_order acc=%b%b%b rows=%0d,%0d exp acc=011 rows=60,61",
                     log_acc[0], log_acc[1], log_acc[2], log_row[1], log_row[2]);
         end
      end
      n_cmp++;
      if (network_time !== 2'd2) begin
         n_bad++;
         $display("FAIL time_after_prio got=%0d exp=2", network_time);
      end
   endtask

   task automatic test_mid_reset();
      int   k = 0;
      logic to;
      ext_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ext_index = 14'(70 + i);
         @(negedge clk);
      end
      ext_valid = 1'b0;
      while (!(busy && c_neuron_index == 4'd4) && k < 50) begin
         @(negedge clk);
         k++;
      end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy, done, ext_ready, c_neuron_we, c_input, spike_out_valid} !== 6'b0 ||
          c_neuron_index !== 4'd0 || c_synapse_index !== 14'd0 || network_time !== 2'd0) begin
         n_bad++;
         $display("FAIL mid_reset flags=%b nidx=%0d sidx=%0d nt=%0d exp all 0",
                  {busy, done, ext_ready, c_neuron_we, c_input, spike_out_valid},
                  c_neuron_index, c_synapse_index, network_time);
      end
      reset = 1'b0;
      @(negedge clk);
      clear_logs();
      pulse_start();
      repeat (80) @(negedge clk);
      n_cmp++;
      if (log_row.size() != 0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL fifo_flushed sweeps=%0d busy=%b exp 0 0", log_row.size(), busy);
      end
      ext_valid = 1'b1;
      ext_index = 14'd80;
      @(negedge clk);
      ext_valid = 1'b0;
      wait_sweeps(1, to);
      n_cmp++;
      if (to !== 1'b0 || log_row.size() != 1 || log_row[0] != 80 || log_acc[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL restart_sweep timeout=%b count=%0d row=%0d exp 0 1 80",
                  to, log_row.size(), (log_row.size() > 0) ? log_row[0] : -1);
      end
   endtask

   task automatic test_done();
      logic to;
      clear_logs();
      for (int t = 0; t < 4; t++) begin
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
         wait_sweeps(t + 1, to);
         n_cmp++;
         if (to !== 1'b0 || network_time !== 2'((t < 3) ? t + 1 : 3) || done !== ((t == 3) ? 1'b1 : 1'b0)) begin
            n_bad++;
            $display("FAIL done_tick%0d timeout=%b nt=%0d done=%b exp 0 %0d %0d",
                     t, to, network_time, done, (t < 3) ? t + 1 : 3, (t == 3) ? 1 : 0);
         end
      end
      n_cmp++;
      if (ext_ready !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL done_ready ready=%b busy=%b exp 0 0", ext_ready, busy);
      end
      pulse_start();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (done !== 1'b1 || network_time !== 2'd3 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL done_sticky done=%b nt=%0d busy=%b exp 1 3 0", done, network_time, busy);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++;
         $display("FAIL done_cleared got=%b exp=0", done);
      end
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      ext_valid = 1'b0;
      ext_index = '0;
      tick      = 1'b0;
      test_reset();
      test_single_event();
      test_fifo_full_order();
      test_fire_feedback();
      test_tick_priority();
      test_mid_reset();
      test_done();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
